// File: rtl/shift_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding and the shift direction
// constants that the shifter and the ALU decode also use.
package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    PASS2 = 3'd2,
    PASS3 = 3'd3,
    DONE  = 3'd4
  } seqState_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_sequencer.sv
// Runs 16-bit logical shifts (0..15) as up to three passes through an external
// 8-bit combinational shifter, merging the bytes and producing C/Z/N flags.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 2 * BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [WORD_W-1:0] OpA,
  input  logic [3:0]        Amt,
  input  logic              Dir,
  output logic [BYTE_W-1:0] ShIn,
  output logic [2:0]        ShAmt,
  output logic              ShDir,
  input  logic [BYTE_W-1:0] ShOut,
  output logic              Busy,
  output logic              Done,
  output logic [WORD_W-1:0] Result,
  output logic              C,
  output logic              Z,
  output logic              N
);

  seqState_t         state, nxtState;
  logic [WORD_W-1:0] opA;
  logic [3:0]        amt;
  logic              dir;
  logic [BYTE_W-1:0] tmpHi, tmpLo, nxtHi, nxtLo;
  logic [BYTE_W-1:0] hi, lo;
  logic [2:0]        k;
  logic              big;

  // Last bit shifted out of the word; indices wrap naturally in 4 bits.
  function automatic logic carryOut(input logic [WORD_W-1:0] w,
                                    input logic [3:0] a, input logic d);
    if (a == 4'd0)
      return 1'b0;
    else if (d == DIR_RIGHT)
      return w[a - 4'd1];
    else
      return w[4'd0 - a];
  endfunction

  assign hi   = opA[WORD_W-1:BYTE_W];
  assign lo   = opA[BYTE_W-1:0];
  assign k    = amt[2:0];
  assign big  = amt[3];
  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  always_comb begin
    nxtState = state;
    ShIn     = '0;
    ShAmt    = '0;
    ShDir    = DIR_LEFT;
    nxtHi    = tmpHi;
    nxtLo    = tmpLo;
    case (state)
      IDLE: if (Start) nxtState = PASS1;
      PASS1: begin
        ShAmt = k;
        ShDir = dir;
        if (dir == DIR_RIGHT) begin
          ShIn  = big ? hi : lo;
          nxtLo = ShOut;
          if (big) nxtHi = '0;
        end else begin
          ShIn  = big ? lo : hi;
          nxtHi = ShOut;
          if (big) nxtLo = '0;
        end
        nxtState = big ? DONE : ((k != 3'd0) ? PASS2 : PASS3);
      end
      PASS2: begin
        // Bits crossing the byte boundary; 0 - k equals 8 - k since k != 0 here.
        ShAmt = 3'd0 - k;
        ShDir = ~dir;
        if (dir == DIR_RIGHT) begin
          ShIn  = hi;
          nxtLo = tmpLo | ShOut;
        end else begin
          ShIn  = lo;
          nxtHi = tmpHi | ShOut;
        end
        nxtState = PASS3;
      end
      PASS3: begin
        ShAmt = k;
        ShDir = dir;
        if (dir == DIR_RIGHT) begin
          ShIn  = hi;
          nxtHi = ShOut;
        end else begin
          ShIn  = lo;
          nxtLo = ShOut;
        end
        nxtState = DONE;
      end
      DONE:    nxtState = IDLE;
      default: nxtState = IDLE;
    endcase
  end

  // Control and architecturally visible result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Result <= '0;
      C      <= 1'b0;
      Z      <= 1'b0;
      N      <= 1'b0;
    end else begin
      state <= nxtState;
      if (nxtState == DONE) begin
        Result <= {nxtHi, nxtLo};
        C      <= carryOut(opA, amt, dir);
        Z      <= ({nxtHi, nxtLo} == '0);
        N      <= nxtHi[BYTE_W-1];
      end
    end
  end

  // Operand latch and temporary bytes
  always_ff @(posedge clk) begin
    tmpHi <= nxtHi;
    tmpLo <= nxtLo;
    if (state == IDLE && Start) begin
      opA <= OpA;
      amt <= Amt;
      dir <= Dir;
    end
  end

endmodule
